// File: rtl/mem_wb_reg.sv
// ---------------------------------------------------------------------------
// mem_wb_reg : MEM/WB pipeline register of the 5-stage 32-bit RISC-V core.
//
// Captures memory read data, ALU result, destination register index and the
// WB-stage control bits at the end of MEM and presents them to write-back
// one cycle later.
//
// Ports
//   clock              rising-edge system clock
//   reset              asynchronous, active-low reset (clears all state)
//   stall              1 = hold all registered outputs
//   flush              1 = load a bubble on the next edge (wins over stall)
//   read_data_in/out   data memory read value
//   ALU_result_in/out  ALU result / address
//   rd_in/out          destination register index
//   WB_reg_write_in/out   register-file write enable
//   WB_mem_to_reg_in/out  WB select: 1 = memory data, 0 = ALU result
//   valid_out          1 = holds a real instruction (not reset/flush bubble)
//   wb_data_out        combinational write-back data select
//
// Optional build macro MEM_WB_PC_TRACE_EN adds pc_in/pc_out and
// instr_in/instr_out (32 bits each) for retirement tracing. They follow the
// same capture/stall/flush/reset rules as the data fields.
// ---------------------------------------------------------------------------
module mem_wb_reg #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned REG_AW = 5
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              stall,
  input  logic              flush,
  input  logic [DATA_W-1:0] read_data_in,
  input  logic [DATA_W-1:0] ALU_result_in,
  input  logic [REG_AW-1:0] rd_in,
  input  logic              WB_reg_write_in,
  input  logic              WB_mem_to_reg_in,
`ifdef MEM_WB_PC_TRACE_EN
  input  logic [31:0]       pc_in,
  input  logic [31:0]       instr_in,
  output logic [31:0]       pc_out,
  output logic [31:0]       instr_out,
`endif
  output logic [DATA_W-1:0] read_data_out,
  output logic [DATA_W-1:0] ALU_result_out,
  output logic [REG_AW-1:0] rd_out,
  output logic              WB_reg_write_out,
  output logic              WB_mem_to_reg_out,
  output logic              valid_out,
  output logic [DATA_W-1:0] wb_data_out
);

  logic [DATA_W-1:0] read_data_q,  read_data_d;
  logic [DATA_W-1:0] alu_result_q, alu_result_d;
  logic [REG_AW-1:0] rd_q,         rd_d;
  logic              reg_write_q,  reg_write_d;
  logic              mem_to_reg_q, mem_to_reg_d;
  logic              valid_q,      valid_d;
`ifdef MEM_WB_PC_TRACE_EN
  logic [31:0]       pc_q,         pc_d;
  logic [31:0]       instr_q,      instr_d;
`endif

  // Next-state: flush beats stall; stall holds; otherwise capture.
  always_comb begin
    read_data_d  = read_data_q;
    alu_result_d = alu_result_q;
    rd_d         = rd_q;
    reg_write_d  = reg_write_q;
    mem_to_reg_d = mem_to_reg_q;
    valid_d      = valid_q;
`ifdef MEM_WB_PC_TRACE_EN
    pc_d         = pc_q;
    instr_d      = instr_q;
`endif
    if (flush) begin
      read_data_d  = '0;
      alu_result_d = '0;
      rd_d         = '0;
      reg_write_d  = 1'b0;
      mem_to_reg_d = 1'b0;
      valid_d      = 1'b0;
`ifdef MEM_WB_PC_TRACE_EN
      pc_d         = '0;
      instr_d      = '0;
`endif
    end else if (!stall) begin
      read_data_d  = read_data_in;
      alu_result_d = ALU_result_in;
      rd_d         = rd_in;
      reg_write_d  = WB_reg_write_in;
      mem_to_reg_d = WB_mem_to_reg_in;
      valid_d      = 1'b1;
`ifdef MEM_WB_PC_TRACE_EN
      pc_d         = pc_in;
      instr_d      = instr_in;
`endif
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      read_data_q  <= '0;
      alu_result_q <= '0;
      rd_q         <= '0;
      reg_write_q  <= 1'b0;
      mem_to_reg_q <= 1'b0;
      valid_q      <= 1'b0;
`ifdef MEM_WB_PC_TRACE_EN
      pc_q         <= '0;
      instr_q      <= '0;
`endif
    end else begin
      read_data_q  <= read_data_d;
      alu_result_q <= alu_result_d;
      rd_q         <= rd_d;
      reg_write_q  <= reg_write_d;
      mem_to_reg_q <= mem_to_reg_d;
      valid_q      <= valid_d;
`ifdef MEM_WB_PC_TRACE_EN
      pc_q         <= pc_d;
      instr_q      <= instr_d;
`endif
    end
  end

  assign read_data_out     = read_data_q;
  assign ALU_result_out    = alu_result_q;
  assign rd_out            = rd_q;
  assign WB_reg_write_out  = reg_write_q;
  assign WB_mem_to_reg_out = mem_to_reg_q;
  assign valid_out         = valid_q;
`ifdef MEM_WB_PC_TRACE_EN
  assign pc_out            = pc_q;
  assign instr_out         = instr_q;
`endif

  assign wb_data_out = mem_to_reg_q ? read_data_q : alu_result_q;

endmodule

// File: tb/tb_mem_wb_reg.sv
module tb_mem_wb_reg;

  logic        clock = 1'b0;
  logic        reset;
  logic        stall;
  logic        flush;
  logic [31:0] read_data_in;
  logic [31:0] ALU_result_in;
  logic [4:0]  rd_in;
  logic        WB_reg_write_in;
  logic        WB_mem_to_reg_in;
  logic [31:0] read_data_out;
  logic [31:0] ALU_result_out;
  logic [4:0]  rd_out;
  logic        WB_reg_write_out;
  logic        WB_mem_to_reg_out;
  logic        valid_out;
  logic [31:0] wb_data_out;
`ifdef MEM_WB_PC_TRACE_EN
  logic [31:0] pc_in = 32'h0;
  logic [31:0] instr_in = 32'h0;
  logic [31:0] pc_out;
  logic [31:0] instr_out;
`endif

  int total = 0;
  int bad   = 0;

  mem_wb_reg #(.DATA_W(32), .REG_AW(5)) dut (
    .clock            (clock),
    .reset            (reset),
    .stall            (stall),
    .flush            (flush),
    .read_data_in     (read_data_in),
    .ALU_result_in    (ALU_result_in),
    .rd_in            (rd_in),
    .WB_reg_write_in  (WB_reg_write_in),
    .WB_mem_to_reg_in (WB_mem_to_reg_in),
`ifdef MEM_WB_PC_TRACE_EN
    .pc_in            (pc_in),
    .instr_in         (instr_in),
    .pc_out           (pc_out),
    .instr_out        (instr_out),
`endif
    .read_data_out    (read_data_out),
    .ALU_result_out   (ALU_result_out),
    .rd_out           (rd_out),
    .WB_reg_write_out (WB_reg_write_out),
    .WB_mem_to_reg_out(WB_mem_to_reg_out),
    .valid_out        (valid_out),
    .wb_data_out      (wb_data_out)
  );

  always #5 clock = ~clock;

  typedef struct {
    string       name;
    logic        st, fl;
    logic [31:0] rdi, alui;
    logic [4:0]  rdni;
    logic        rwi, m2ri;
    logic [31:0] erd, ealu;
    logic [4:0]  erdn;
    logic        erw, em2r, ev;
  } vec_t;

  vec_t vecs[11];

  function automatic vec_t mk(string n, logic st, logic fl,
                              logic [31:0] rdi, logic [31:0] alui, logic [4:0] rdni,
                              logic rwi, logic m2ri,
                              logic [31:0] erd, logic [31:0] ealu, logic [4:0] erdn,
                              logic erw, logic em2r, logic ev);
    vec_t v;
    v.name = n; v.st = st; v.fl = fl;
    v.rdi = rdi; v.alui = alui; v.rdni = rdni; v.rwi = rwi; v.m2ri = m2ri;
    v.erd = erd; v.ealu = ealu; v.erdn = erdn; v.erw = erw; v.em2r = em2r; v.ev = ev;
    return v;
  endfunction

  // Expected write-back select derived from the expected fields.
  task automatic check(string name, logic [31:0] erd, logic [31:0] ealu, logic [4:0] erdn,
                       logic erw, logic em2r, logic ev);
    logic [31:0]  ewb;
    logic [103:0] act, exp;
    ewb = em2r ? erd : ealu;
    act = {read_data_out, ALU_result_out, rd_out, WB_reg_write_out, WB_mem_to_reg_out,
           valid_out, wb_data_out};
    exp = {erd, ealu, erdn, erw, em2r, ev, ewb};
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got rd=%h alu=%h rd_idx=%0d rw=%b m2r=%b v=%b wb=%h ; want rd=%h alu=%h rd_idx=%0d rw=%b m2r=%b v=%b wb=%h",
               name, read_data_out, ALU_result_out, rd_out, WB_reg_write_out,
               WB_mem_to_reg_out, valid_out, wb_data_out,
               erd, ealu, erdn, erw, em2r, ev, ewb);
    end
  endtask

  task automatic drive(logic st, logic fl, logic [31:0] rdi, logic [31:0] alui,
                       logic [4:0] rdni, logic rwi, logic m2ri);
    stall = st; flush = fl;
    read_data_in = rdi; ALU_result_in = alui; rd_in = rdni;
    WB_reg_write_in = rwi; WB_mem_to_reg_in = m2ri;
  endtask

  initial begin
    vecs[0]  = mk("load_mem",  0,0, 32'd1234, 32'd12345, 5'd31, 1,1, 32'd1234, 32'd12345, 5'd31, 1,1,1);
    vecs[1]  = mk("sel_alu",   0,0, 32'd1234, 32'd12345, 5'd31, 1,0, 32'd1234, 32'd12345, 5'd31, 1,0,1);
    vecs[2]  = mk("reload",    0,0, 32'd1234, 32'd12345, 5'd31, 1,1, 32'd1234, 32'd12345, 5'd31, 1,1,1);
    vecs[3]  = mk("stall1",    1,0, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd7, 0,0, 32'd1234, 32'd12345, 5'd31, 1,1,1);
    vecs[4]  = mk("stall2",    1,0, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd7, 0,0, 32'd1234, 32'd12345, 5'd31, 1,1,1);
    vecs[5]  = mk("stall3",    1,0, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd7, 0,0, 32'd1234, 32'd12345, 5'd31, 1,1,1);
    vecs[6]  = mk("unstall",   0,0, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd7, 0,0, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd7, 0,0,1);
    vecs[7]  = mk("stall_flush",1,1, 32'd1234, 32'd12345, 5'd31, 1,1, 32'd0, 32'd0, 5'd0, 0,0,0);
    vecs[8]  = mk("flush_only",0,1, 32'd99, 32'd77, 5'd3, 1,1, 32'd0, 32'd0, 5'd0, 0,0,0);
    vecs[9]  = mk("pattern",   0,0, 32'hA5A5A5A5, 32'h5A5A5A5A, 5'd5, 1,0, 32'hA5A5A5A5, 32'h5A5A5A5A, 5'd5, 1,0,1);
    vecs[10] = mk("load_full", 0,0, 32'd1234, 32'd12345, 5'd31, 1,1, 32'd1234, 32'd12345, 5'd31, 1,1,1);

    // Reset held from time 0, inputs non-zero so a leak would show.
    reset = 1'b0;
    drive(0, 0, 32'd1234, 32'd12345, 5'd31, 1, 1);
    #1 check("reset_async", 0, 0, 0, 0, 0, 0);
    @(posedge clock); #1;
    check("reset_held_edge", 0, 0, 0, 0, 0, 0);
    #1 reset = 1'b1;
    #1 check("reset_release", 0, 0, 0, 0, 0, 0);

    for (int i = 0; i < 11; i++) begin
      drive(vecs[i].st, vecs[i].fl, vecs[i].rdi, vecs[i].alui, vecs[i].rdni,
            vecs[i].rwi, vecs[i].m2ri);
      @(posedge clock); #1;
      check(vecs[i].name, vecs[i].erd, vecs[i].ealu, vecs[i].erdn,
            vecs[i].erw, vecs[i].em2r, vecs[i].ev);
    end

    // Asynchronous reset between edges with everything loaded; stall/flush low.
    #2 reset = 1'b0;
    #1 check("midcycle_reset", 0, 0, 0, 0, 0, 0);
    drive(1, 0, 32'd5, 32'd6, 5'd7, 1, 1);
    @(posedge clock); #1;
    check("reset_over_stall", 0, 0, 0, 0, 0, 0);
    drive(0, 0, 32'd5, 32'd6, 5'd7, 1, 1);
    @(posedge clock); #1;
    check("reset_over_capture", 0, 0, 0, 0, 0, 0);
    #1 reset = 1'b1;
    #1 check("release_no_capture", 0, 0, 0, 0, 0, 0);
    @(posedge clock); #1;
    check("first_capture", 32'd5, 32'd6, 5'd7, 1, 1, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: simulation did not complete, required finish before 20000");
    $fatal(1);
  end

endmodule

// File: doc/mem_wb_reg.md
Name: mem_wb_reg

Overview:
- MEM/WB pipeline register of the 5-stage 32-bit RISC-V core.
- Captures memory read data, ALU result, destination register and WB-stage control at the end of MEM, and presents them to the write-back stage one cycle later.
- Supports stall (hold) and flush (bubble insertion).
- Provides a combinational write-back data select for convenience.

Parameters:
- DATA_W, 32, width of the read_data and ALU_result paths.
- REG_AW, 5, width of the register index rd.

Ports:
- clock  in  1  single system clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- stall  in  1  1 = hold all registered outputs.
- flush  in  1  1 = load a bubble on the next edge.
- read_data_in  in  DATA_W  data memory read value.
- ALU_result_in  in  DATA_W  ALU result or address from the EX/MEM stage.
- rd_in  in  REG_AW  destination register index.
- WB_reg_write_in  in  1  register-file write enable for WB.
- WB_mem_to_reg_in  in  1  WB select: 1 = memory data, 0 = ALU result.
- read_data_out  out  DATA_W  registered read_data.
- ALU_result_out  out  DATA_W  registered ALU result.
- rd_out  out  REG_AW  registered rd.
- WB_reg_write_out  out  1  registered reg_write.
- WB_mem_to_reg_out  out  1  registered mem_to_reg.
- valid_out  out  1  1 = the register holds a real instruction rather than a reset or flush bubble.
- wb_data_out  out  DATA_W  combinational: WB_mem_to_reg_out ? read_data_out : ALU_result_out.

Behaviour:
- Reset: while reset=0, all registered outputs are cleared to 0 immediately, independent of clock. This covers read_data_out, ALU_result_out, rd_out, WB_reg_write_out, WB_mem_to_reg_out and valid_out, so wb_data_out also reads 0.
- Reset release: after reset returns to 1, the first capture happens on the next rising clock edge.
- Latency: exactly one cycle. Inputs sampled at rising edge N appear on the outputs right after edge N and stay stable until the next update.
- Normal capture (stall=0, flush=0): every *_out takes its *_in value, and valid_out becomes 1.
- Stall (stall=1, flush=0): all registered outputs hold their current values.
- Flush (flush=1):
  - Control bits WB_reg_write_out and WB_mem_to_reg_out are cleared, and valid_out is cleared.
  - read_data_out, ALU_result_out and rd_out are cleared to 0.
  - Flush has priority over stall.
- Reset mid-operation: reset asserted at any point clears state at once, overriding stall and flush. No partial updates occur.
- Undriven or X inputs: these are captured as-is. No sanitising is done except under flush or reset.
- wb_data_out: purely combinational from the registered outputs. No extra latency; it changes only when the registers change.
- No arithmetic, so no width conversions. All paths are bit-for-bit copies.

Optional Feature:
- Macro: MEM_WB_PC_TRACE_EN.
- When defined:
  - Adds ports pc_in / pc_out (32 bits) and instr_in / instr_out (32 bits).
  - These follow the same capture, stall, flush and reset rules as the data fields; reset and flush value is 0.
  - Used for retirement tracing.
- When undefined: these ports and registers do not exist, and all other behaviour is unchanged.

Test Plan:
- Reset=0 for one cycle, then release. Expect all outputs 0 both during reset and immediately after release, before any capture edge.
- Release reset, drive WB_reg_write_in=1 and WB_mem_to_reg_in=1, then apply one edge. Expect WB_reg_write_out=1, WB_mem_to_reg_out=1 and valid_out=1.
- Drive read_data_in=1234, ALU_result_in=12345, rd_in=31, then apply one edge:
  - Expect read_data_out=1234, ALU_result_out=12345, rd_out=31.
  - Expect wb_data_out=1234 with mem_to_reg=1, and 12345 after switching mem_to_reg to 0 and applying one edge.
- Hold loaded values and assert stall=1, then change the inputs to 0xFFFFFFFF and rd=7 over 3 edges. Expect the outputs to stay at 1234 / 12345 / 31. Deassert stall and apply one edge; expect the new values.
- Assert stall=1 and flush=1 together, then apply one edge. Expect all data and control outputs at 0 and valid_out=0 (flush wins).
- With 1234/12345/31 and both control bits 1 loaded, assert reset=0 between clock edges (asynchronously). Expect all outputs 0 immediately without waiting for an edge, and still 0 one cycle later while reset is held.
